// File: rtl/shift_pkg.sv
// Shared types and helpers for the universal shift register and its shift counter.
package shift_pkg;

   typedef enum logic [1:0] {
      SH_HOLD  = 2'b00,
      SH_RIGHT = 2'b01,
      SH_LEFT  = 2'b10,
      SH_LOAD  = 2'b11
   } shift_mode_t;

   // Counter width for a WIDTH-bit word; never narrower than one bit.
   function automatic int unsigned cnt_width(input int unsigned width);
      return (width <= 1) ? 1 : $clog2(width);
   endfunction

endpackage

// File: rtl/shift_cnt.sv
// Modulo-WIDTH shift counter with a one-edge WORD_DONE pulse on each completed word.
module shift_cnt
   import shift_pkg::*;
#(
   parameter int unsigned WIDTH    = 8,
   parameter bit          NEG_EDGE = 1'b1,
   localparam int unsigned CNT_W   = cnt_width(WIDTH)
) (
   input  logic             CLK,
   input  logic             RST_N,
   input  logic             inc,
   input  logic             clr,
   output logic [CNT_W-1:0] cnt,
   output logic             word_done
);

   logic [CNT_W-1:0] r_cnt;
   logic             r_done;
   logic [CNT_W-1:0] w_cnt_nxt;
   logic             w_done_nxt;

   // Wrap at WIDTH-1 so back-to-back words pulse without a gap cycle.
   always_comb begin
      w_cnt_nxt  = r_cnt;
      w_done_nxt = 1'b0;
      if (clr) begin
         w_cnt_nxt = '0;
      end else if (inc) begin
         if (r_cnt == CNT_W'(WIDTH - 1)) begin
            w_cnt_nxt  = '0;
            w_done_nxt = 1'b1;
         end else begin
            w_cnt_nxt = r_cnt + CNT_W'(1);
         end
      end
   end

   generate
      if (NEG_EDGE) begin : g_neg
         always_ff @(negedge CLK or negedge RST_N) begin
            if (!RST_N) begin
               r_cnt  <= '0;
               r_done <= 1'b0;
            end else begin
               r_cnt  <= w_cnt_nxt;
               r_done <= w_done_nxt;
            end
         end
      end else begin : g_pos
         always_ff @(posedge CLK or negedge RST_N) begin
            if (!RST_N) begin
               r_cnt  <= '0;
               r_done <= 1'b0;
            end else begin
               r_cnt  <= w_cnt_nxt;
               r_done <= w_done_nxt;
            end
         end
      end
   endgenerate

   assign cnt       = r_cnt;
   assign word_done = r_done;

endmodule

// File: rtl/univ_shift_reg.sv
// Universal shift register: hold, shift right/left and parallel load on a selectable edge.
module univ_shift_reg
   import shift_pkg::*;
#(
   parameter int unsigned      WIDTH     = 8,
   parameter bit               NEG_EDGE  = 1'b1,
   parameter logic [WIDTH-1:0] RESET_VAL = '0,
   localparam int unsigned     CNT_W     = cnt_width(WIDTH)
) (
   input  logic             CLK,
   input  logic             RST_N,
   input  logic             EN,
   input  logic [1:0]       MODE,
   input  logic [WIDTH-1:0] D,
   input  logic             SIN_MSB,
   input  logic             SIN_LSB,
   output logic [WIDTH-1:0] Q,
   output logic             SOUT_LSB,
   output logic             SOUT_MSB,
   output logic [CNT_W-1:0] CNT,
   output logic             WORD_DONE
);

   logic [WIDTH-1:0] r_q;
   logic [WIDTH-1:0] w_q_nxt;
   logic [WIDTH-1:0] w_shr;
   logic [WIDTH-1:0] w_shl;
   logic             w_inc;
   logic             w_clr;
   shift_mode_t      w_mode;

   // A one-bit register simply takes the serial input in either direction.
   generate
      if (WIDTH == 1) begin : g_w1
         assign w_shr = SIN_MSB;
         assign w_shl = SIN_LSB;
      end else begin : g_wn
         assign w_shr = {SIN_MSB, r_q[WIDTH-1:1]};
         assign w_shl = {r_q[WIDTH-2:0], SIN_LSB};
      end
   endgenerate

   assign w_mode = shift_mode_t'(MODE);

   always_comb begin
      w_q_nxt = r_q;
      w_inc   = 1'b0;
      w_clr   = 1'b0;
      if (EN) begin
         unique case (w_mode)
            SH_RIGHT: begin
               w_q_nxt = w_shr;
               w_inc   = 1'b1;
            end
            SH_LEFT: begin
               w_q_nxt = w_shl;
               w_inc   = 1'b1;
            end
            SH_LOAD: begin
               w_q_nxt = D;
               w_clr   = 1'b1;
            end
            default: ;
         endcase
      end
   end

   generate
      if (NEG_EDGE) begin : g_neg
         always_ff @(negedge CLK or negedge RST_N) begin
            if (!RST_N) r_q <= RESET_VAL;
            else        r_q <= w_q_nxt;
         end
      end else begin : g_pos
         always_ff @(posedge CLK or negedge RST_N) begin
            if (!RST_N) r_q <= RESET_VAL;
            else        r_q <= w_q_nxt;
         end
      end
   endgenerate

   shift_cnt #(
      .WIDTH    (WIDTH),
      .NEG_EDGE (NEG_EDGE)
   ) u_cnt (
      .CLK       (CLK),
      .RST_N     (RST_N),
      .inc       (w_inc),
      .clr       (w_clr),
      .cnt       (CNT),
      .word_done (WORD_DONE)
   );

   assign Q        = r_q;
   assign SOUT_LSB = r_q[0];
   assign SOUT_MSB = r_q[WIDTH-1];

endmodule

// File: tb/tb_univ_shift_reg.sv
// Bench for univ_shift_reg: 8-bit falling-edge, 8-bit rising-edge and 1-bit variants on shared stimulus.
module tb_univ_shift_reg;

   logic       CLK;
   logic       RST_N;
   logic       EN;
   logic [1:0] MODE;
   logic [7:0] D8;
   logic [0:0] D1;
   logic       SIN_MSB;
   logic       SIN_LSB;

   logic [7:0] q8n, q8p;
   logic [2:0] cnt8n, cnt8p;
   logic       sl8n, sm8n, done8n, sl8p, sm8p, done8p;
   logic [0:0] q1, cnt1;
   logic       sl1, sm1, done1;

   assign D1 = D8[0];

   univ_shift_reg #(.WIDTH(8), .NEG_EDGE(1'b1), .RESET_VAL(8'h00)) dut8n (
      .CLK(CLK), .RST_N(RST_N), .EN(EN), .MODE(MODE), .D(D8),
      .SIN_MSB(SIN_MSB), .SIN_LSB(SIN_LSB), .Q(q8n), .SOUT_LSB(sl8n),
      .SOUT_MSB(sm8n), .CNT(cnt8n), .WORD_DONE(done8n));

   univ_shift_reg #(.WIDTH(8), .NEG_EDGE(1'b0), .RESET_VAL(8'h00)) dut8p (
      .CLK(CLK), .RST_N(RST_N), .EN(EN), .MODE(MODE), .D(D8),
      .SIN_MSB(SIN_MSB), .SIN_LSB(SIN_LSB), .Q(q8p), .SOUT_LSB(sl8p),
      .SOUT_MSB(sm8p), .CNT(cnt8p), .WORD_DONE(done8p));

   univ_shift_reg #(.WIDTH(1), .NEG_EDGE(1'b1), .RESET_VAL(1'b0)) dut1 (
      .CLK(CLK), .RST_N(RST_N), .EN(EN), .MODE(MODE), .D(D1),
      .SIN_MSB(SIN_MSB), .SIN_LSB(SIN_LSB), .Q(q1), .SOUT_LSB(sl1),
      .SOUT_MSB(sm1), .CNT(cnt1), .WORD_DONE(done1));

   always #5 CLK = ~CLK;

   int n_checks = 0;
   int n_errors = 0;

   // Reference: word value as an integer plus number of shifts since the last load/reset.
   int m8_q, m8_n, m8_d;
   int m1_q, m1_n, m1_d;

   typedef struct {
      logic       en;
      logic [1:0] mode;
      logic [7:0] d;
      logic       smsb;
      logic       slsb;
      logic [7:0] eq;
      logic [2:0] ec;
      logic       ed;
   } vec_t;
   vec_t vecs[$];

   function automatic void add(logic en, logic [1:0] mode, logic [7:0] d, logic smsb,
                               logic slsb, logic [7:0] eq, logic [2:0] ec, logic ed);
      vec_t v;
      v = '{en, mode, d, smsb, slsb, eq, ec, ed};
      vecs.push_back(v);
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic void model_reset();
      m8_q = 0; m8_n = 0; m8_d = 0;
      m1_q = 0; m1_n = 0; m1_d = 0;
   endfunction

   function automatic void model_apply(logic en, logic [1:0] mode, logic [7:0] d,
                                       logic smsb, logic slsb);
      m8_d = 0;
      m1_d = 0;
      if (!en || mode == 2'b00) return;
      if (mode == 2'b11) begin
         m8_q = int'(d);    m8_n = 0;
         m1_q = int'(d[0]); m1_n = 0;
         return;
      end
      if (mode == 2'b01) begin
         m8_q = m8_q / 2 + int'(smsb) * 128;
         m1_q = m1_q / 2 + int'(smsb);
      end else begin
         m8_q = (m8_q * 2 + int'(slsb)) % 256;
         m1_q = (m1_q * 2 + int'(slsb)) % 2;
      end
      m8_n++;
      m1_n++;
      m8_d = (m8_n % 8 == 0) ? 1 : 0;
      m1_d = (m1_n % 1 == 0) ? 1 : 0;
   endfunction

   task automatic chk8(input string tag, input logic [7:0] q, input logic [2:0] c,
                       input logic dn, input logic sl, input logic sm);
      chk({tag, " Q"},         32'(q),  32'(m8_q));
      chk({tag, " CNT"},       32'(c),  32'(m8_n % 8));
      chk({tag, " WORD_DONE"}, 32'(dn), 32'(m8_d));
      chk({tag, " SOUT_LSB"},  32'(sl), 32'(m8_q % 2));
      chk({tag, " SOUT_MSB"},  32'(sm), 32'(m8_q / 128));
   endtask

   task automatic chk1(input string tag);
      chk({tag, " w1 Q"},         32'(q1),    32'(m1_q));
      chk({tag, " w1 CNT"},       32'(cnt1),  32'(m1_n % 1));
      chk({tag, " w1 WORD_DONE"}, 32'(done1), 32'(m1_d));
      chk({tag, " w1 SOUT"},      32'({sl1, sm1}), 32'(m1_q * 3));
   endtask

   // Called just after a falling edge; the rising-edge DUT captures first, then the falling-edge ones.
   task automatic step(input string tag, input logic en, input logic [1:0] mode,
                       input logic [7:0] d, input logic smsb, input logic slsb);
      int oq, on;
      EN = en; MODE = mode; D8 = d; SIN_MSB = smsb; SIN_LSB = slsb;
      oq = m8_q;
      on = m8_n;
      model_apply(en, mode, d, smsb, slsb);
      @(posedge CLK); #1;
      chk8({tag, " pos"}, q8p, cnt8p, done8p, sl8p, sm8p);
      chk({tag, " neg unchanged at rise Q"},   32'(q8n),   32'(oq));
      chk({tag, " neg unchanged at rise CNT"}, 32'(cnt8n), 32'(on % 8));
      @(negedge CLK); #1;
      chk8({tag, " neg"}, q8n, cnt8n, done8n, sl8n, sm8n);
      chk1(tag);
   endtask

   // Assert reset between edges and check it takes effect without any clock edge.
   task automatic pulse_reset(input string tag);
      #1 RST_N = 1'b0;
      model_reset();
      #1;
      chk8({tag, " neg"}, q8n, cnt8n, done8n, sl8n, sm8n);
      chk8({tag, " pos"}, q8p, cnt8p, done8p, sl8p, sm8p);
      chk1(tag);
      @(negedge CLK); #1 RST_N = 1'b1;
   endtask

   initial begin
      CLK = 1'b0; RST_N = 1'b1; EN = 1'b0; MODE = 2'b00; D8 = 8'h00;
      SIN_MSB = 1'b0; SIN_LSB = 1'b0;
      model_reset();
      #2 RST_N = 1'b0;
      #1;
      chk8("power-on reset neg", q8n, cnt8n, done8n, sl8n, sm8n);
      chk8("power-on reset pos", q8p, cnt8p, done8p, sl8p, sm8p);
      chk1("power-on reset");
      @(negedge CLK); #1 RST_N = 1'b1;

      step("load A5", 1'b1, 2'b11, 8'hA5, 1'b0, 1'b0);
      pulse_reset("async reset");

      add(1, 2'b11, 8'h3C, 0, 0, 8'h3C, 0, 0);
      add(1, 2'b11, 8'h81, 0, 0, 8'h81, 0, 0);
      add(1, 2'b01, 8'h00, 0, 0, 8'h40, 1, 0);
      add(1, 2'b01, 8'h00, 0, 0, 8'h20, 2, 0);
      add(1, 2'b01, 8'h00, 0, 0, 8'h10, 3, 0);
      add(1, 2'b01, 8'h00, 0, 0, 8'h08, 4, 0);
      add(1, 2'b01, 8'h00, 0, 0, 8'h04, 5, 0);
      add(1, 2'b01, 8'h00, 0, 0, 8'h02, 6, 0);
      add(1, 2'b01, 8'h00, 0, 0, 8'h01, 7, 0);
      add(1, 2'b01, 8'h00, 0, 0, 8'h00, 0, 1);
      add(1, 2'b11, 8'h00, 0, 0, 8'h00, 0, 0);
      add(1, 2'b10, 8'h00, 0, 1, 8'h01, 1, 0);
      add(1, 2'b10, 8'h00, 0, 0, 8'h02, 2, 0);
      add(1, 2'b10, 8'h00, 0, 1, 8'h05, 3, 0);
      add(1, 2'b10, 8'h00, 0, 1, 8'h0B, 4, 0);
      add(1, 2'b10, 8'h00, 0, 0, 8'h16, 5, 0);
      add(1, 2'b10, 8'h00, 0, 0, 8'h2C, 6, 0);
      add(1, 2'b10, 8'h00, 0, 1, 8'h59, 7, 0);
      add(1, 2'b10, 8'h00, 0, 0, 8'hB2, 0, 1);
      add(1, 2'b01, 8'h00, 1, 0, 8'hD9, 1, 0);
      add(1, 2'b01, 8'h00, 1, 0, 8'hEC, 2, 0);
      add(1, 2'b01, 8'h00, 1, 0, 8'hF6, 3, 0);
      for (int k = 0; k < 4; k++) add(0, 2'b01, 8'h00, 1, 1, 8'hF6, 3, 0);
      add(1, 2'b00, 8'h00, 1, 1, 8'hF6, 3, 0);
      add(1, 2'b10, 8'h00, 0, 0, 8'hEC, 4, 0);
      add(1, 2'b10, 8'h00, 0, 0, 8'hD8, 5, 0);
      add(1, 2'b10, 8'h00, 0, 0, 8'hB0, 6, 0);
      add(1, 2'b10, 8'h00, 0, 0, 8'h60, 7, 0);
      add(1, 2'b10, 8'h00, 0, 0, 8'hC0, 0, 1);
      add(1, 2'b01, 8'h00, 0, 0, 8'h60, 1, 0);
      add(1, 2'b01, 8'h00, 0, 0, 8'h30, 2, 0);
      add(1, 2'b01, 8'h00, 0, 0, 8'h18, 3, 0);
      add(1, 2'b01, 8'h00, 0, 0, 8'h0C, 4, 0);
      add(1, 2'b01, 8'h00, 0, 0, 8'h06, 5, 0);
      add(1, 2'b11, 8'hFF, 0, 0, 8'hFF, 0, 0);
      add(0, 2'b11, 8'h00, 0, 0, 8'hFF, 0, 0);
      add(1, 2'b01, 8'h00, 0, 0, 8'h7F, 1, 0);
      add(1, 2'b01, 8'h00, 0, 0, 8'h3F, 2, 0);
      add(1, 2'b01, 8'h00, 0, 0, 8'h1F, 3, 0);
      add(1, 2'b01, 8'h00, 0, 0, 8'h0F, 4, 0);
      add(1, 2'b01, 8'h00, 0, 0, 8'h07, 5, 0);
      add(1, 2'b01, 8'h00, 0, 0, 8'h03, 6, 0);

      foreach (vecs[i]) begin
         string tag;
         tag = $sformatf("vec%0d", i);
         step(tag, vecs[i].en, vecs[i].mode, vecs[i].d, vecs[i].smsb, vecs[i].slsb);
         chk({tag, " table Q"},         32'(q8n),    32'(vecs[i].eq));
         chk({tag, " table CNT"},       32'(cnt8n),  32'(vecs[i].ec));
         chk({tag, " table WORD_DONE"}, 32'(done8n), 32'(vecs[i].ed));
      end

      pulse_reset("reset mid-word");
      chk("reset mid-word table Q",   32'(q8n),   32'h00);
      chk("reset mid-word table CNT", 32'(cnt8n), 32'h0);

      for (int i = 0; i < 400; i++) begin
         if ($urandom_range(0, 49) == 0) begin
            pulse_reset($sformatf("rnd%0d reset", i));
         end else begin
            step($sformatf("rnd%0d", i), ($urandom_range(0, 7) != 0),
                 2'($urandom_range(0, 3)), 8'($urandom), 1'($urandom), 1'($urandom));
         end
      end

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
